// File: rtl/tinuc_mmio_pkg.sv
// Shared register map and control-bit layout for the TinuC data-side MMIO window.
package tinuc_mmio_pkg;

    localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFF_CYCLE    = 4'd2;
    localparam logic [3:0] OFF_CMP      = 4'd3;
    localparam logic [3:0] OFF_CNT      = 4'd4;
    localparam logic [3:0] OFF_CTRL     = 4'd5;
    localparam logic [3:0] OFF_STAT     = 4'd6;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQEN  = 2;

    typedef struct packed {
        logic cmp;
        logic cnt;
        logic ctrl;
        logic stat;
    } timer_we_t;

endpackage

// File: rtl/tinuc_timer.sv
// Compare timer: free counter CNT against CMP, sticky match flag, level interrupt.
module tinuc_timer
    import tinuc_mmio_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  timer_we_t   we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] cmp_o,
    output logic [31:0] cnt_o,
    output logic [2:0]  ctrl_o,
    output logic        match_o,
    output logic        irq_o
);

    logic [31:0] cmp_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [2:0]  ctrl_q;
    logic        match_q;
    logic        match_d;
    logic        hit;

    assign hit = ctrl_q[CTRL_EN] && (cnt_q == cmp_q);

    // CPU write to CNT overrides counting; a fresh match wins over a w1c clear.
    always_comb begin
        cnt_d = cnt_q;
        if (ctrl_q[CTRL_EN]) begin
            cnt_d = (hit && ctrl_q[CTRL_RELOAD]) ? 32'd0 : cnt_q + 32'd1;
        end
        if (we_i.cnt) begin
            cnt_d = wdata_i;
        end
        match_d = match_q;
        if (we_i.stat && wdata_i[0]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_q   <= 32'hFFFF_FFFF;
            cnt_q   <= 32'd0;
            ctrl_q  <= 3'd0;
            match_q <= 1'b0;
        end else begin
            if (we_i.cmp) begin
                cmp_q <= wdata_i;
            end
            if (we_i.ctrl) begin
                ctrl_q <= wdata_i[2:0];
            end
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign cmp_o   = cmp_q;
    assign cnt_o   = cnt_q;
    assign ctrl_o  = ctrl_q;
    assign match_o = match_q;
    assign irq_o   = match_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: rtl/tinuc_dmem_mmio.sv
// TinuC data-bus responder: word RAM, GPIO, cycle counter and compare timer.
module tinuc_dmem_mmio
    import tinuc_mmio_pkg::*;
#(
    parameter int         RAM_WORDS = 240,
    parameter logic [9:0] MMIO_BASE = 10'h3C0,
    parameter int         GPIO_W    = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [9:0]        daddr,
    input  logic [31:0]       ddata_w,
    input  logic              d_rw,
    output logic [31:0]       ddata_r,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam logic [8:0] RAM_LIMIT = 9'(RAM_WORDS);

    logic [31:0]       ram [RAM_WORDS];
    logic [7:0]        wordIdx;
    logic [3:0]        off;
    logic              isMmio;
    logic              isRam;
    logic              mmioWr;
    logic [GPIO_W-1:0] gpioOut_q;
    logic [GPIO_W-1:0] sync1_q;
    logic [GPIO_W-1:0] sync2_q;
    logic [31:0]       cycle_q;
    timer_we_t         timerWe;
    logic [31:0]       tmrCmp;
    logic [31:0]       tmrCnt;
    logic [2:0]        tmrCtrl;
    logic              tmrMatch;

    assign wordIdx = daddr[9:2];
    assign off     = daddr[5:2];
    assign isMmio  = (daddr >= MMIO_BASE);
    assign isRam   = !isMmio && ({1'b0, wordIdx} < RAM_LIMIT);
    assign mmioWr  = d_rw && isMmio;

    always_comb begin
        timerWe      = '0;
        timerWe.cmp  = mmioWr && (off == OFF_CMP);
        timerWe.cnt  = mmioWr && (off == OFF_CNT);
        timerWe.ctrl = mmioWr && (off == OFF_CTRL);
        timerWe.stat = mmioWr && (off == OFF_STAT);
    end

    // RAM has no reset, but a write in a reset cycle must still be dropped.
    always_ff @(posedge CLK) begin
        if (!RESET && d_rw && isRam) begin
            ram[wordIdx] <= ddata_w;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            gpioOut_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            cycle_q   <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            if (mmioWr && (off == OFF_GPIO_OUT)) begin
                gpioOut_q <= ddata_w[GPIO_W-1:0];
            end
        end
    end

    tinuc_timer uTimer (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .we_i    (timerWe),
        .wdata_i (ddata_w),
        .cmp_o   (tmrCmp),
        .cnt_o   (tmrCnt),
        .ctrl_o  (tmrCtrl),
        .match_o (tmrMatch),
        .irq_o   (timer_irq)
    );

    // Unmapped MMIO offsets and the address hole both fall through to zero.
    always_comb begin
        ddata_r = 32'd0;
        if (isMmio) begin
            case (off)
                OFF_GPIO_OUT: ddata_r[GPIO_W-1:0] = gpioOut_q;
                OFF_GPIO_IN:  ddata_r[GPIO_W-1:0] = sync2_q;
                OFF_CYCLE:    ddata_r = cycle_q;
                OFF_CMP:      ddata_r = tmrCmp;
                OFF_CNT:      ddata_r = tmrCnt;
                OFF_CTRL:     ddata_r[2:0] = tmrCtrl;
                OFF_STAT:     ddata_r[0] = tmrMatch;
                default:      ddata_r = 32'd0;
            endcase
        end else if (isRam) begin
            ddata_r = ram[wordIdx];
        end
    end

    assign gpio_out = gpioOut_q;

endmodule

// File: tb/tb_tinuc_dmem_mmio.sv
// Bench for tinuc_dmem_mmio: directed scenarios with literal expectations plus random traffic vs a model.
module tb_tinuc_dmem_mmio;

    logic        CLK;
    logic        RESET;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        d_rw;
    logic [31:0] ddata_r;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;
    bit monOn  = 0;

    tinuc_dmem_mmio dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .daddr     (daddr),
        .ddata_w   (ddata_w),
        .d_rw      (d_rw),
        .ddata_r   (ddata_r),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference state, described in register-map terms.
    logic [31:0] mRam [240];
    bit          mRamOk [240];
    logic [7:0]  mGpioOut, mS1, mS2;
    logic [31:0] mCycle, mCmp, mCnt;
    bit          mEn, mReload, mIrqEn, mMatch;

    initial begin
        for (int i = 0; i < 240; i++) mRamOk[i] = 0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [9:0] a, output bit known);
        int w;
        w = int'(a[9:2]);
        known = 1;
        modelRead = 32'd0;
        if (a >= 10'h3C0) begin
            case (w - 240)
                0: modelRead = {24'd0, mGpioOut};
                1: modelRead = {24'd0, mS2};
                2: modelRead = mCycle;
                3: modelRead = mCmp;
                4: modelRead = mCnt;
                5: modelRead = {29'd0, mIrqEn, mReload, mEn};
                6: modelRead = {31'd0, mMatch};
                default: modelRead = 32'd0;
            endcase
        end else if (w < 240) begin
            known = mRamOk[w];
            modelRead = mRam[w];
        end
    endfunction

    // Advance the model by one clock using the inputs present before the edge.
    always @(posedge CLK) begin
        logic [31:0] nCnt;
        bit          nMatch, hit;
        int          w;
        if (RESET) begin
            mGpioOut = 8'd0; mS1 = 8'd0; mS2 = 8'd0;
            mCycle = 32'd0; mCmp = 32'hFFFF_FFFF; mCnt = 32'd0;
            mEn = 0; mReload = 0; mIrqEn = 0; mMatch = 0;
        end else begin
            hit    = mEn && (mCnt == mCmp);
            nCnt   = !mEn ? mCnt : ((hit && mReload) ? 32'd0 : mCnt + 32'd1);
            nMatch = mMatch;
            w      = int'(daddr[9:2]);
            if (d_rw) begin
                if (daddr >= 10'h3C0) begin
                    case (w - 240)
                        0: mGpioOut = ddata_w[7:0];
                        3: mCmp = ddata_w;
                        4: nCnt = ddata_w;
                        5: {mIrqEn, mReload, mEn} = ddata_w[2:0];
                        6: if (ddata_w[0]) nMatch = 0;
                        default: ;
                    endcase
                end else if (w < 240) begin
                    mRam[w]   = ddata_w;
                    mRamOk[w] = 1;
                end
            end
            if (hit) nMatch = 1;
            mCnt   = nCnt;
            mMatch = nMatch;
            mS2    = mS1;
            mS1    = gpio_in;
            mCycle = mCycle + 32'd1;
        end
    end

    always @(negedge CLK) begin
        logic [31:0] exp;
        bit          known;
        if (monOn) begin
            exp = modelRead(daddr, known);
            if (known) checkOutput("model ddata_r", ddata_r, exp);
            checkOutput("model gpio_out", {24'd0, gpio_out}, {24'd0, mGpioOut});
            checkOutput("model timer_irq", {31'd0, timer_irq}, {31'd0, mMatch && mIrqEn});
        end
    end

    task automatic applyStimulus(input logic [9:0] a, input logic [31:0] w, input logic rw,
                                 input logic [7:0] gin, input logic rst);
        @(posedge CLK);
        #1;
        daddr   = a;
        ddata_w = w;
        d_rw    = rw;
        gpio_in = gin;
        RESET   = rst;
        @(negedge CLK);
    endtask

    initial begin
        logic [9:0]  a;
        logic [31:0] w;
        int          r, o;
        int          cntSeq[7];
        cntSeq = '{0, 1, 2, 3, 4, 5, 0};

        RESET = 1'b1; daddr = 10'd0; ddata_w = 32'd0; d_rw = 1'b0; gpio_in = 8'd0;
        repeat (2) @(posedge CLK);
        monOn = 1;

        applyStimulus(10'h3C8, 0, 0, 8'h00, 0);
        checkOutput("reset CYCLE", ddata_r, 32'd0);
        checkOutput("reset gpio_out", {24'd0, gpio_out}, 32'd0);
        checkOutput("reset irq", {31'd0, timer_irq}, 32'd0);
        applyStimulus(10'h3CC, 0, 0, 8'h00, 0);
        checkOutput("reset CMP", ddata_r, 32'hFFFF_FFFF);
        applyStimulus(10'h3C8, 0, 0, 8'h00, 0);
        checkOutput("CYCLE count", ddata_r, 32'd2);

        for (int i = 0; i < 240; i++) applyStimulus(10'(i * 4), $urandom, 1, 8'h00, 0);

        applyStimulus(10'h010, 32'hDEADBEEF, 1, 8'h00, 0);
        applyStimulus(10'h010, 0, 0, 8'h00, 0);
        checkOutput("RAM read 0x010", ddata_r, 32'hDEADBEEF);
        applyStimulus(10'h013, 0, 0, 8'h00, 0);
        checkOutput("RAM read 0x013", ddata_r, 32'hDEADBEEF);
        applyStimulus(10'h3BC, 32'h1234_5678, 1, 8'h00, 0);
        applyStimulus(10'h3BC, 0, 0, 8'h00, 0);
        checkOutput("RAM last word", ddata_r, 32'h1234_5678);
        applyStimulus(10'h3E0, 0, 0, 8'h00, 0);
        checkOutput("MMIO reserved", ddata_r, 32'd0);

        applyStimulus(10'h020, 32'd1, 1, 8'h00, 0);
        applyStimulus(10'h020, 32'd2, 1, 8'h00, 0);
        checkOutput("same-cycle old", ddata_r, 32'd1);
        applyStimulus(10'h020, 0, 0, 8'h00, 0);
        checkOutput("same-cycle new", ddata_r, 32'd2);

        applyStimulus(10'h3C4, 0, 0, 8'hA5, 0);
        applyStimulus(10'h3C4, 0, 0, 8'hA5, 0);
        checkOutput("GPIO_IN t+1", ddata_r, 32'd0);
        applyStimulus(10'h3C4, 0, 0, 8'hA5, 0);
        checkOutput("GPIO_IN t+2", ddata_r, 32'hA5);
        applyStimulus(10'h3C0, 32'h3C, 1, 8'h00, 0);
        applyStimulus(10'h3C0, 0, 0, 8'h00, 0);
        checkOutput("gpio_out", {24'd0, gpio_out}, 32'h3C);

        applyStimulus(10'h3CC, 32'd5, 1, 8'h00, 0);
        applyStimulus(10'h3D0, 32'd0, 1, 8'h00, 0);
        applyStimulus(10'h3D4, 32'd7, 1, 8'h00, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
            checkOutput("timer CNT seq", ddata_r, 32'(cntSeq[i]));
            checkOutput("timer irq seq", {31'd0, timer_irq}, {31'd0, i == 6});
        end
        applyStimulus(10'h3D8, 32'd1, 1, 8'h00, 0);
        checkOutput("STAT before w1c", ddata_r, 32'd1);
        applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
        checkOutput("CNT after w1c", ddata_r, 32'd2);
        checkOutput("irq cleared", {31'd0, timer_irq}, 32'd0);
        applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
        checkOutput("CNT 3", ddata_r, 32'd3);
        applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
        checkOutput("CNT 4", ddata_r, 32'd4);
        applyStimulus(10'h3D8, 32'd1, 1, 8'h00, 0);
        checkOutput("STAT at hit", ddata_r, 32'd0);
        applyStimulus(10'h3D8, 0, 0, 8'h00, 0);
        checkOutput("set beats clear", ddata_r, 32'd1);
        checkOutput("irq after set", {31'd0, timer_irq}, 32'd1);
        applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
        applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
        applyStimulus(10'h3D0, 32'h55, 1, 8'h00, 1);
        checkOutput("CNT before reset", ddata_r, 32'd3);
        applyStimulus(10'h3C8, 0, 0, 8'h00, 0);
        checkOutput("mid reset CYCLE", ddata_r, 32'd0);
        checkOutput("mid reset irq", {31'd0, timer_irq}, 32'd0);
        checkOutput("mid reset gpio_out", {24'd0, gpio_out}, 32'd0);
        applyStimulus(10'h3D0, 0, 0, 8'h00, 0);
        checkOutput("mid reset CNT", ddata_r, 32'd0);
        applyStimulus(10'h3D4, 0, 0, 8'h00, 0);
        checkOutput("mid reset CTRL", ddata_r, 32'd0);
        applyStimulus(10'h3CC, 0, 0, 8'h00, 0);
        checkOutput("mid reset CMP", ddata_r, 32'hFFFF_FFFF);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            o = int'($urandom_range(0, 9));
            w = $urandom;
            if (r < 5) begin
                a = 10'(10'h3C0 + 10'(o * 4) + 10'($urandom_range(0, 3)));
                if (o == 3 || o == 4) w = 32'($urandom_range(0, 12));
            end else begin
                a = 10'($urandom_range(0, 959));
            end
            applyStimulus(a, w, $urandom_range(0, 2) == 0, 8'($urandom),
                          $urandom_range(0, 299) == 0);
        end

        @(posedge CLK);
        monOn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
